traffic_display_drv: RTL and testbench
======================================

TRAFFIC_DISPLAY_DRV -- requirements
Module: traffic_display_drv

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000: sys_clk frequency in Hz.
REQ-002 Parameter SCAN_HZ, default 1000: per-digit scan rate in Hz.
REQ-003 Parameter BLINK_TH, default 3: countdown values 1..BLINK_TH blink on the display.
REQ-004 Port sys_clk, input, 1: single clock for all logic.
REQ-005 Port sys_rst_p, input, 1: reset, synchronous, active-high.
REQ-006 Port light_t, input, 8: remaining seconds from the traffic light controller, binary.
REQ-007 Port light_ctrl, input, 3: light state, one-hot: 001 green, 010 yellow, 100 red, 000 idle.
REQ-008 Port seg, output, 8: segments, active-low; bit0=a … bit6=g, bit7=dp.
REQ-009 Port dig_sel, output, 4: digit enables, active-low; bit0=ones, bit1=tens, bit2=hundreds, bit3=state letter.
REQ-010 Port led_rgb, output, 3: registered copy of light_ctrl for discrete lamps.
REQ-011 Port bcd_busy, output, 1: high while a binary-to-BCD conversion is in progress.

Function
REQ-012 light_t and light_ctrl SHALL be registered through two flops before any use, because they originate in another clock domain.
REQ-013 Converter FSM states: IDLE, LOAD, SHIFT, DONE.
REQ-014 IDLE->LOAD when synced light_t != last converted value. LOAD captures the value and clears the scratch register, then goes to SHIFT.
REQ-015 SHIFT runs 8 double-dabble iterations, one per cycle: add 3 to any BCD nibble >= 5, then shift left 1. After iteration 8 it goes to DONE.
REQ-016 DONE latches hundreds/tens/ones into the display registers and records the converted value, then goes to IDLE. Latency from input change to display update is 10 cycles after sync.
REQ-017 bcd_busy SHALL be high in LOAD, SHIFT and DONE, and low in IDLE.
REQ-018 If light_t changes mid-conversion, the current conversion completes. A new conversion starts from IDLE on the next cycle; there is no abort.
REQ-019 The scan prescaler counts 0..CLK_FREQ/(4*SCAN_HZ)-1. On wrap, the digit index advances 0→1→2→3→0.
REQ-020 Exactly one dig_sel bit SHALL be low at any time after reset. seg and dig_sel SHALL change on the same clock edge.
REQ-021 Digit encodings: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
REQ-022 Hundreds digit SHALL be blank when 0. Tens digit SHALL be blank when both hundreds and tens are 0. Ones digit SHALL always be shown.
REQ-023 Letter digit: green=C2 ('G'), yellow=91 ('Y'), red=AF ('r'), idle 000=FF, any multi-hot value=BF ('-').
REQ-024 The blink phase toggles every CLK_FREQ/4 cycles (2 Hz).
REQ-025 When the displayed value is in 1..BLINK_TH and the blink phase is 0, the three numeric digits SHALL drive FF. The letter digit is never blanked.
REQ-026 Displayed value 0 SHALL not blink.
REQ-027 led_rgb SHALL equal synced light_ctrl delayed one cycle, with no blinking.
REQ-028 Counter widths SHALL be sized with clog2 of their terminal count. No counter may overflow for any legal parameter set.

Reset
REQ-029 On sys_rst_p high at a rising edge, all of the following SHALL take their reset values on that edge:
 - seg=FF, dig_sel=1110, led_rgb=000, bcd_busy=0
 - FSM=IDLE, prescaler=0, digit index=0, blink phase=1
 - display registers=0, last converted value=0
REQ-030 Reset asserted mid-conversion SHALL abandon the conversion. The display shows ones=0 until a new conversion completes.
REQ-031 After release, a nonzero light_t SHALL trigger a conversion automatically.

Verification (CLK_FREQ=1000, SCAN_HZ=25 → 10 cycles/digit, blink toggle 250 cycles)
REQ-032 Reset, light_t=0, light_ctrl=000:
 - dig_sel cycles 1110,1101,1011,0111 every 10 cycles.
 - seg reads C0, FF, FF, FF per digit (ones, tens, hundreds, letter).
REQ-033 light_t=20, light_ctrl=001:
 - bcd_busy high for 10 cycles starting 2 cycles after the input change.
 - Digits then read ones=C0, tens=A4, hundreds=FF, letter=C2.
REQ-034 light_t=255, light_ctrl=100:
 - ones=92, tens=92, hundreds=A4, letter=AF.
REQ-035 light_t=3, light_ctrl=010:
 - Numeric digits alternate between B0 and FF every 250 cycles; letter stays 91.
 - Then light_t=0: ones shows C0 steadily, no blink.
REQ-036 Change light_t 17→14 on the 3rd SHIFT cycle:
 - The first conversion completes and latches 17.
 - A second conversion follows, and the display ends at 14.
REQ-037 light_ctrl=011:
 - Letter digit reads BF.
 - led_rgb=011, appearing 3 cycles after the input change.

Source files
------------

// File: rtl/traffic_display_drv_if.sv
// Bus between the traffic light controller and the 7-segment display driver.
// Signals:
//   light_t    - remaining seconds, binary (controller -> driver)
//   light_ctrl - light state, one-hot: 001 green, 010 yellow, 100 red, 000 idle
//   seg        - segments, active-low, bit0=a .. bit6=g, bit7=dp
//   dig_sel    - digit enables, active-low: ones, tens, hundreds, letter
//   led_rgb    - registered light state for discrete lamps
//   bcd_busy   - binary-to-BCD conversion in progress
interface traffic_display_drv_if;
  logic [7:0] light_t;
  logic [2:0] light_ctrl;
  logic [7:0] seg;
  logic [3:0] dig_sel;
  logic [2:0] led_rgb;
  logic       bcd_busy;

  modport master (
    output light_t, light_ctrl,
    input  seg, dig_sel, led_rgb, bcd_busy
  );

  modport slave (
    input  light_t, light_ctrl,
    output seg, dig_sel, led_rgb, bcd_busy
  );
endinterface

// File: rtl/traffic_display_drv.sv
// Four-digit multiplexed 7-segment driver for a traffic light countdown.
// Shows the remaining seconds (up to three digits, leading zeros blanked)
// plus a state letter, blinks the numeric digits for the last seconds,
// and mirrors the light state onto discrete lamps.
// Ports:
//   sys_clk   - single clock
//   sys_rst_p - synchronous active-high reset
//   bus       - slave side of traffic_display_drv_if (inputs light_t /
//               light_ctrl, outputs seg / dig_sel / led_rgb / bcd_busy)
module traffic_display_drv #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_TH = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_p,
  traffic_display_drv_if.slave  bus
);

  localparam int SCAN_RAW  = CLK_FREQ / (4 * SCAN_HZ);
  localparam int SCAN_DIV  = (SCAN_RAW > 1) ? SCAN_RAW : 1;
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_RAW = CLK_FREQ / 4;
  localparam int BLINK_DIV = (BLINK_RAW > 1) ? BLINK_RAW : 1;
  localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  // Two-flop synchronizers for the foreign-domain inputs
  logic [7:0] t_s1, t_s2;
  logic [2:0] c_s1, c_s2;

  // Converter
  state_t     state;
  logic       busy;
  logic [7:0] conv_val;
  logic [7:0] bin;
  logic [11:0] bcd;
  logic [2:0] shift_cnt;
  logic [19:0] dd_next;

  // Display registers; last_val is both the last converted and the shown value
  logic [7:0] last_val;
  logic [3:0] hund, tens, ones;

  // Scan and blink timing
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         dig_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  // Outputs
  logic [7:0] seg_r, seg_n;
  logic [3:0] sel_r, sel_n;
  logic [2:0] led_r;
  logic       blank_num;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [7:0] enc_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] enc_letter(input logic [2:0] c);
    case (c)
      3'b000:  return 8'hFF;
      3'b001:  return 8'hC2;
      3'b010:  return 8'h91;
      3'b100:  return 8'hAF;
      default: return 8'hBF;
    endcase
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      t_s1 <= '0;
      t_s2 <= '0;
      c_s1 <= '0;
      c_s2 <= '0;
    end else begin
      t_s1 <= bus.light_t;
      t_s2 <= t_s1;
      c_s1 <= bus.light_ctrl;
      c_s2 <= c_s1;
    end
  end

  // One double-dabble iteration: adjust every BCD nibble, then shift the
  // whole {bcd, bin} scratch left so the next binary MSB enters the ones nibble.
  always_comb begin
    dd_next = '0;
    dd_next = {dd_adj(bcd[11:8]), dd_adj(bcd[7:4]), dd_adj(bcd[3:0]), bin} << 1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      state     <= IDLE;
      busy      <= 1'b0;
      conv_val  <= '0;
      bin       <= '0;
      bcd       <= '0;
      shift_cnt <= '0;
      last_val  <= '0;
      hund      <= '0;
      tens      <= '0;
      ones      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (t_s2 != last_val) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          conv_val  <= t_s2;
          bin       <= t_s2;
          bcd       <= '0;
          shift_cnt <= '0;
          state     <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin} <= dd_next;
          shift_cnt  <= shift_cnt + 3'd1;
          if (shift_cnt == 3'd7) state <= DONE;
        end
        DONE: begin
          hund     <= bcd[11:8];
          tens     <= bcd[7:4];
          ones     <= bcd[3:0];
          last_val <= conv_val;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      scan_cnt    <= '0;
      dig_idx     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        dig_idx  <= dig_idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    blank_num = (last_val != '0) && (int'(last_val) <= BLINK_TH) && !blink_phase;
    seg_n = 8'hFF;
    sel_n = ~(4'b0001 << dig_idx);
    case (dig_idx)
      2'd0: seg_n = blank_num ? 8'hFF : enc_digit(ones);
      2'd1: seg_n = (blank_num || (hund == 4'd0 && tens == 4'd0)) ? 8'hFF : enc_digit(tens);
      2'd2: seg_n = (blank_num || hund == 4'd0) ? 8'hFF : enc_digit(hund);
      default: seg_n = enc_letter(c_s2);
    endcase
  end

  // seg and dig_sel are both registered from the same dig_idx so they
  // switch on the same edge.
  always_ff @(posedge sys_clk) begin
    if (sys_rst_p) begin
      seg_r <= 8'hFF;
      sel_r <= 4'b1110;
      led_r <= '0;
    end else begin
      seg_r <= seg_n;
      sel_r <= sel_n;
      led_r <= c_s2;
    end
  end

  assign bus.seg      = seg_r;
  assign bus.dig_sel  = sel_r;
  assign bus.led_rgb  = led_r;
  assign bus.bcd_busy = busy;

endmodule

// File: tb/tb_traffic_display_drv.sv
// Directed bench for traffic_display_drv at CLK_FREQ=1000, SCAN_HZ=25
// (10 cycles per digit, blink phase toggles every 250 cycles).
module tb_traffic_display_drv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  traffic_display_drv_if bus();

  traffic_display_drv #(
    .CLK_FREQ(1000),
    .SCAN_HZ (25),
    .BLINK_TH(3)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_p(rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the given digit to be selected and returns its
  // segments; returns X on timeout so the caller's comparison fails.
  task automatic read_digit(input logic [3:0] sel, output logic [7:0] s);
    int n = 0;
    @(negedge clk);
    while (bus.dig_sel !== sel && n < 60) begin
      @(negedge clk);
      n++;
    end
    s = (n < 60) ? bus.seg : 8'hxx;
  endtask

  logic [7:0] s;
  int first, cnt, bad, n;
  logic [3:0] prev;
  bit seen_on, seen_off;

  initial begin
    bus.light_t    = 8'd0;
    bus.light_ctrl = 3'b000;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_seg", bus.seg, 8'hFF);
    check("rst_dig_sel", bus.dig_sel, 4'b1110);
    check("rst_led", bus.led_rgb, 3'b000);
    check("rst_busy", bus.bcd_busy, 1'b0);
    rst = 1'b0;

    // Value 0, idle: ones C0, rest blank, 10-cycle slots, one-hot-low select
    read_digit(4'b1110, s); check("zero_ones", s, 8'hC0);
    read_digit(4'b1101, s); check("zero_tens", s, 8'hFF);
    read_digit(4'b1011, s); check("zero_hund", s, 8'hFF);
    read_digit(4'b0111, s); check("idle_letter", s, 8'hFF);
    read_digit(4'b1101, s);
    n = 1;
    while (bus.dig_sel === 4'b1101 && n < 50) begin
      @(negedge clk);
      if (bus.dig_sel === 4'b1101) n++;
    end
    check("slot_len", n, 10);
    bad = 0;
    prev = bus.dig_sel;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!(bus.dig_sel inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) bad++;
      if (bus.dig_sel !== prev) begin
        if (bus.dig_sel !== {prev[2:0], prev[3]}) bad++;
        prev = bus.dig_sel;
      end
    end
    check("scan_order", bad, 0);

    // 20 green: busy window, digits
    bus.light_t = 8'd20;
    bus.light_ctrl = 3'b001;
    first = 0;
    cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.bcd_busy === 1'b1) begin
        if (first == 0) first = k;
        cnt++;
      end
    end
    check("busy_start_2to3", (first >= 2 && first <= 3), 1);
    check("busy_len", cnt, 10);
    read_digit(4'b1110, s); check("t20_ones", s, 8'hC0);
    read_digit(4'b1101, s); check("t20_tens", s, 8'hA4);
    read_digit(4'b1011, s); check("t20_hund", s, 8'hFF);
    read_digit(4'b0111, s); check("green_letter", s, 8'hC2);
    check("green_led", bus.led_rgb, 3'b001);

    // 255 red
    bus.light_t = 8'd255;
    bus.light_ctrl = 3'b100;
    repeat (20) @(negedge clk);
    read_digit(4'b1110, s); check("t255_ones", s, 8'h92);
    read_digit(4'b1101, s); check("t255_tens", s, 8'h92);
    read_digit(4'b1011, s); check("t255_hund", s, 8'hA4);
    read_digit(4'b0111, s); check("red_letter", s, 8'hAF);

    // Multi-hot light state: led delay and dash letter
    bus.light_ctrl = 3'b011;
    repeat (2) @(negedge clk);
    check("led_not_yet", bus.led_rgb, 3'b100);
    @(negedge clk);
    check("led_3cyc", bus.led_rgb, 3'b011);
    read_digit(4'b0111, s); check("multi_letter", s, 8'hBF);

    // 17 -> 14 during the third SHIFT cycle, aligned to the scan frame
    prev = bus.dig_sel;
    n = 0;
    @(negedge clk);
    while (!(prev !== 4'b0111 && bus.dig_sel === 4'b0111) && n < 60) begin
      prev = bus.dig_sel;
      @(negedge clk);
      n++;
    end
    check("align_frame", (n < 60), 1);
    bus.light_t = 8'd17;
    repeat (6) @(negedge clk);
    check("busy_mid", bus.bcd_busy, 1'b1);
    bus.light_t = 8'd14;
    repeat (10) @(negedge clk);
    check("first_conv_sel", bus.dig_sel, 4'b1110);
    check("first_conv_17", bus.seg, 8'hF8);
    check("second_conv_busy", bus.bcd_busy, 1'b1);
    repeat (20) @(negedge clk);
    read_digit(4'b1110, s); check("t14_ones", s, 8'h99);
    read_digit(4'b1101, s); check("t14_tens", s, 8'hF9);

    // 3 yellow: numeric digits blink, letter steady
    bus.light_t = 8'd3;
    bus.light_ctrl = 3'b010;
    repeat (20) @(negedge clk);
    seen_on = 0; seen_off = 0; bad = 0; cnt = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.dig_sel === 4'b1110) begin
        if (bus.seg === 8'hB0) seen_on = 1;
        else if (bus.seg === 8'hFF) seen_off = 1;
        else bad++;
      end
      if (bus.dig_sel === 4'b0111 && bus.seg !== 8'h91) cnt++;
      if (bus.dig_sel === 4'b1101 && bus.seg !== 8'hFF) bad++;
    end
    check("blink_on_seen", seen_on, 1);
    check("blink_off_seen", seen_off, 1);
    check("blink_values", bad, 0);
    check("letter_no_blink", cnt, 0);

    // 4 is above the threshold: steady
    bus.light_t = 8'd4;
    repeat (20) @(negedge clk);
    bad = 0; cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.dig_sel === 4'b1110) begin
        cnt++;
        if (bus.seg !== 8'h99) bad++;
      end
    end
    check("t4_steady", bad, 0);
    check("t4_sampled", (cnt > 0), 1);

    // 0 never blinks
    bus.light_t = 8'd0;
    repeat (20) @(negedge clk);
    bad = 0; cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.dig_sel === 4'b1110) begin
        cnt++;
        if (bus.seg !== 8'hC0) bad++;
      end
    end
    check("t0_steady", bad, 0);
    check("t0_sampled", (cnt > 0), 1);

    // Reset mid-conversion, then automatic reconversion of 105
    bus.light_t = 8'd105;
    bus.light_ctrl = 3'b001;
    n = 0;
    while (bus.bcd_busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("busy_before_rst", bus.bcd_busy, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", bus.bcd_busy, 1'b0);
    check("midrst_seg", bus.seg, 8'hFF);
    check("midrst_sel", bus.dig_sel, 4'b1110);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_sel", bus.dig_sel, 4'b1110);
    check("postrst_ones0", bus.seg, 8'hC0);
    n = 0;
    while (bus.bcd_busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("auto_conv", bus.bcd_busy, 1'b1);
    repeat (20) @(negedge clk);
    read_digit(4'b1110, s); check("t105_ones", s, 8'h92);
    read_digit(4'b1101, s); check("t105_tens", s, 8'hC0);
    read_digit(4'b1011, s); check("t105_hund", s, 8'hF9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
